serial_add_sub: RTL and testbench

- Parametrised, multi-cycle, digit-serial adder/subtractor for the fixed-point datapath. It extends the single-bit full-adder cell in both width and mode.
- Processes DIGIT bits per clock, LSB digit first, with a start/busy/done handshake.
- Used wherever a full-width carry chain in one cycle is too slow or too large, e.g. residual and correction updates in the Goldschmidt divider.

---
 rtl/serial_add_sub.sv | 121 ++++++++++++
 tb/tb_serial_add_sub.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first.
// Define SERIAL_ADD_SUB_SATURATE_EN to clamp the sum on signed overflow.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (WIDTH % DIGIT != 0) begin : g_bad_digit
            $error("serial_add_sub: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dsum;
    logic             c_next;
    logic             c_msb;
    logic             ovf_next;
    logic             last;

    assign busy = (state == RUN);
    assign last = (cnt == CW'(N - 1));

    // c_msb ends up as the carry into the top bit of the digit,
    // which on the last digit is the carry into bit WIDTH-1.
    always_comb begin : digit_ripple
        logic c;
        c     = carry;
        c_msb = carry;
        dsum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i] = a_sh[i] ^ b_sh[i] ^ c;
            c_msb   = c;
            c       = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
        end
        c_next = c;
        r_next = r_sh >> DIGIT;
        r_next[WIDTH-1 -: DIGIT] = dsum;
        ovf_next = c_msb ^ c_next;
    end

    always_comb begin
        result = r_next;
`ifdef SERIAL_ADD_SUB_SATURATE_EN
        if (ovf_next) begin
            result = c_next ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{sub}};
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    r_sh  <= r_next;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        sum   <= result;
                        c_out <= c_next;
                        ovf   <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub (WIDTH=16, DIGIT=4).
// Honours SERIAL_ADD_SUB_SATURATE_EN in its reference model.
module tb_serial_add_sub;

    localparam int W = 16;
    localparam int D = 4;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    serial_add_sub #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic s, input logic ci);
        exp_t       e;
        logic [W:0] t;
        if (!s) begin
            t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            e.co = t[W];
            e.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        end else begin
            t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
            e.co = ~t[W];
            e.ov = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
        end
        e.sum = t[W-1:0];
`ifdef SERIAL_ADD_SUB_SATURATE_EN
        if (e.ov) e.sum = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("c_out", 32'(c_out), 32'(e.co));
                check("ovf", 32'(ovf), 32'(e.ov));
                check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Call at a negedge; returns at a negedge with start low.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic ci,
                         input int hold, input bit push);
        exp_t e;
        start = 1'b1;
        a     = x;
        b     = y;
        sub   = s;
        c_in  = ci;
        e     = model(x, y, s, ci);
        e.cyc = cyc + 1 + N;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        a    = W'($urandom);
        b    = W'($urandom);
        sub  = 1'($urandom);
        c_in = 1'($urandom);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        if (i == 100) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == 100) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(c_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b1);
        check("busy_run", 32'(busy), 32'd1);
        wait_idle();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        issue(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b1);
        wait_idle();
        issue(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b1);
        wait_idle();
        issue(16'h8000, 16'hFFFF, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        issue(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b1);
        wait_idle();

        // start held through RUN, then a new start in the done cycle
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1, N - 1, 1'b1);
        wait_done();
        check("done_busy", 32'(busy), 32'd0);
        issue(16'hA5A5, 16'h1111, 1'b1, 1'b0, 0, 1'b1);
        wait_done();
        issue(16'h0101, 16'h7F7F, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom),
                  1'($urandom), 0, 1'b1);
            wait_idle();
        end

        // reset on the 2nd busy cycle aborts the operation
        issue(16'h1357, 16'h2468, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(c_out), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (N + 2) @(negedge clk);
        issue(16'h4000, 16'h4000, 1'b0, 1'b0, 0, 1'b1);
        wait_idle();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
